burst_summator: RTL
===================

// Module: burst_summator
// PURPOSE
//   Parametrised streaming summator: accepts a burst of cfg_len unsigned samples on a valid/ready
//   input, accumulates them and presents the total on a valid/ready output until it is consumed.
//   Next generation of the fixed 8-sample summing block. Adds configurable width and burst length,
//   runtime burst length, backpressure and overflow reporting. Sits between a sample source and a
//   result consumer.
// PARAMETERS
//   DATA_W   8   sample width, bits
//   MAX_LEN  8   maximum samples per burst (>=1)
//   SUM_W    16  accumulator/result width, bits (>= DATA_W)
//   LEN_W    $clog2(MAX_LEN+1)  width of cfg_len/out_cnt (derived, localparam)
// PORTS
//   clk        in   1        clock, rising edge
//   reset      in   1        asynchronous reset, active-high
//   start      in   1        begin new burst; honoured only in IDLE
//   cfg_len    in   LEN_W    samples in burst, sampled with start; values >MAX_LEN clamp to MAX_LEN
//   in_valid   in   1        sample valid
//   in_data    in   DATA_W   sample, unsigned
//   in_ready   out  1        block accepts sample
//   out_valid  out  1        result valid
//   out_sum    out  SUM_W    burst total
//   out_cnt    out  LEN_W    samples summed in this burst
//   out_ovf    out  1        overflow occurred during burst
//   out_ready  in   1        consumer takes result
//   busy       out  1        state != IDLE
// BEHAVIOUR
//   - Reset (async, any state, mid-burst included): state=IDLE, acc=0, cnt=0, ovf=0. All outputs 0.
//     The partial burst is discarded.
//   - FSM states are IDLE, ACCUM, DONE.
//   - IDLE: in_ready=0, out_valid=0.
//     start=1 latches len=min(cfg_len,MAX_LEN) and clears acc/cnt/ovf.
//     Next state: ACCUM if len>0. DONE if len==0 (out_sum=0, out_cnt=0).
//   - ACCUM: in_ready=1. Each cycle with in_valid&in_ready: acc<=acc+in_data (zero-extended to
//     SUM_W+1), cnt<=cnt+1. Beat that makes cnt==len moves to DONE next cycle.
//     in_valid=0 stalls without limit. start is ignored.
//   - DONE: out_valid=1. out_sum, out_cnt and out_ovf are held stable while out_ready=0.
//     out_valid&out_ready moves to IDLE. start is ignored in DONE, including on the handshake
//     cycle, so back-to-back bursts need one IDLE cycle.
//   - Latency: result is valid 1 cycle after the last accepted beat. Minimum burst period is
//     len+2 cycles.
//   - Outputs are registered. in_ready and out_valid decode directly from the state register.
//   - Arithmetic: the add is SUM_W+1 bits wide; a carry out sets the sticky ovf for this burst.
//   - in_data is ignored when in_valid=0 or outside ACCUM.
// CONFIGURATION
//   SUMMATOR_SATURATE_EN
//     defined:   on carry out, acc clamps to {SUM_W{1'b1}} and stays there for the rest of the
//                burst; ovf=1.
//     undefined: acc wraps modulo 2^SUM_W; ovf=1 flags that a wrap happened.
//     cnt and handshake behaviour are identical in both builds.
// STRUCTURE
//   - Package summator_pkg: typedef enum logic [1:0] {IDLE, ACCUM, DONE} sum_state_t; function
//     clog2-based LEN_W helper.
//   - One sub-module, sum_acc_core: registered SUM_W accumulator with clear, add-enable, carry
//     detect and the SUMMATOR_SATURATE_EN clamp. The top holds the FSM, counter and handshakes.
// TESTING
//   1. Defaults; start, cfg_len=7; feed 1,5,9,2,6,7,1 back-to-back; out_ready=1
//      -> out_sum=31, out_cnt=7, out_ovf=0, out_valid high exactly 1 cycle.
//   2. cfg_len=3, samples 10,20,30 with in_valid gaps of 2 cycles; out_ready low 5 cycles
//      -> out_sum=60 held stable until out_ready; busy high throughout.
//   3. cfg_len=0 -> DONE next cycle, out_sum=0, out_cnt=0; cfg_len=15 -> clamps, 8 beats accepted.
//   4. SUM_W=8, cfg_len=2, samples 200,100. Without macro: out_sum=44, out_ovf=1.
//      With SUMMATOR_SATURATE_EN: out_sum=255, out_ovf=1.
//   5. Assert reset after 2 of 4 beats -> all outputs 0 immediately (async).
//      New burst 4,4,4,4 -> out_sum=16, no residue from the aborted burst.
//   6. start pulsed during ACCUM and on the DONE handshake cycle -> ignored; next start accepted
//      only in IDLE.

Source files
------------

// File: rtl/summator_pkg.sv
// Shared types and width helper for the burst summator.
package summator_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} sum_state_t;

   // Width needed to hold any count 0..max_len inclusive.
   function automatic int len_w_f(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/sum_acc_core.sv
// Registered accumulator with clear, add-enable and sticky carry-out flag.
// Build option SUMMATOR_SATURATE_EN: clamp to all-ones on carry instead of wrapping.
module sum_acc_core #(
   parameter int DATA_W = 8,
   parameter int SUM_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              add_en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [SUM_W-1:0]  acc_o,
   output logic              ovf_o
);

   logic [SUM_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [SUM_W:0]   sum_ext;

   always_comb begin
      sum_ext = {1'b0, acc_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, data_i};
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      if (clr_i) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (add_en_i) begin
`ifdef SUMMATOR_SATURATE_EN
         // Once clamped, the total stays pinned for the rest of the burst.
         if (sum_ext[SUM_W] || ovf_q) begin
            acc_d = '1;
         end else begin
            acc_d = sum_ext[SUM_W-1:0];
         end
`else
         acc_d = sum_ext[SUM_W-1:0];
`endif
         ovf_d = ovf_q | sum_ext[SUM_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc_o = acc_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/burst_summator.sv
// Streaming burst summator: FSM, beat counter and handshakes around sum_acc_core.
// Build option SUMMATOR_SATURATE_EN selects saturating instead of wrapping accumulation.
module burst_summator
   import summator_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int MAX_LEN = 8,
   parameter  int SUM_W   = 16,
   localparam int LEN_W   = len_w_f(MAX_LEN)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [SUM_W-1:0]  out_sum,
   output logic [LEN_W-1:0]  out_cnt,
   output logic              out_ovf,
   input  logic              out_ready,
   output logic              busy
);

   sum_state_t       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_clamped;
   logic [LEN_W-1:0] cnt_inc;
   logic             acc_clr;
   logic             acc_add;

   assign len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
   assign cnt_inc     = cnt_q + LEN_W'(1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      acc_clr = 1'b0;
      acc_add = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_d   = len_clamped;
               cnt_d   = '0;
               acc_clr = 1'b1;
               state_d = (len_clamped == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               acc_add = 1'b1;
               cnt_d   = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // start is deliberately not looked at here, even on the handshake cycle.
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

   sum_acc_core #(
      .DATA_W (DATA_W),
      .SUM_W  (SUM_W)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (acc_clr),
      .add_en_i (acc_add),
      .data_i   (in_data),
      .acc_o    (out_sum),
      .ovf_o    (out_ovf)
   );

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_cnt   = cnt_q;

endmodule
